// File: rtl/gcm_out_collector.sv
// Collects GCM output words into a small show-ahead buffer, counts message bytes,
// captures the tag and compares it against the expected tag latched at start.
module gcm_out_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [127:0] Out_data,
    input  logic         Out_vld,
    input  logic         Tag_vld,
    input  logic [3:0]   Out_data_size,
    input  logic         Out_last_word,
    input  logic         start,
    input  logic [127:0] exp_tag,
    input  logic         rd_en,
    output logic [127:0] rd_data,
    output logic [3:0]   rd_size,
    output logic         rd_last,
    output logic         rd_empty,
    output logic         fifo_full,
    output logic [AW:0]  fifo_count,
    output logic [15:0]  byte_cnt,
    output logic [127:0] tag_out,
    output logic         busy,
    output logic         done,
    output logic         tag_match,
    output logic         overflow,
    output logic         seq_err
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [127:0]    data_mem [DEPTH];
    logic [3:0]      size_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [127:0]    tag_q, tag_d, exp_q, exp_d;
    logic            match_q, match_d, ovf_q, ovf_d, seq_q, seq_d;
    logic            last_seen_q, last_seen_d;
    logic            empty, full, do_pop, data_word, tag_word, do_wr;
    logic [127:0]    wr_data;
    logic [16:0]     byte_sum;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    // The start cycle clears the buffer, so neither pops nor writes take effect then.
    assign do_pop    = rd_en & ~empty & ~start;
    assign data_word = ~start & (state_q == S_COLLECT) & Out_vld & ~Tag_vld;
    assign tag_word  = ~start & (state_q == S_COLLECT) & Out_vld & Tag_vld;
    assign do_wr     = data_word & (~full | do_pop);
    assign byte_sum  = {1'b0, byte_cnt_q} + 17'(Out_data_size) + 17'd1;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            wr_data[8*i +: 8] = (4'(i) <= Out_data_size) ? Out_data[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        byte_cnt_d  = byte_cnt_q;
        tag_d       = tag_q;
        exp_d       = exp_q;
        match_d     = match_q;
        ovf_d       = ovf_q;
        seq_d       = seq_q;
        last_seen_d = last_seen_q;
        if (start) begin
            state_d     = S_COLLECT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            byte_cnt_d  = '0;
            tag_d       = '0;
            exp_d       = exp_tag;
            match_d     = 1'b0;
            ovf_d       = 1'b0;
            seq_d       = 1'b0;
            last_seen_d = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                byte_cnt_d = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
                if (Out_last_word) last_seen_d = 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_wr && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_wr && do_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (data_word && last_seen_q) seq_d = 1'b1;
            if (data_word && !do_wr) ovf_d = 1'b1;
            if (tag_word) begin
                tag_d   = Out_data;
                match_d = (Out_data == exp_q);
                state_d = S_DONE;
                if (!last_seen_q) seq_d = 1'b1;
            end
            if (state_q == S_DONE && Out_vld) seq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            byte_cnt_q  <= '0;
            tag_q       <= '0;
            exp_q       <= '0;
            match_q     <= 1'b0;
            ovf_q       <= 1'b0;
            seq_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            byte_cnt_q  <= byte_cnt_d;
            tag_q       <= tag_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            ovf_q       <= ovf_d;
            seq_q       <= seq_d;
            last_seen_q <= last_seen_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the count is zero.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            data_mem[wr_ptr_q] <= wr_data;
            size_mem[wr_ptr_q] <= Out_data_size;
            last_mem[wr_ptr_q] <= Out_last_word;
        end
    end

    assign rd_data    = empty ? '0 : data_mem[rd_ptr_q];
    assign rd_size    = empty ? '0 : size_mem[rd_ptr_q];
    assign rd_last    = empty ? 1'b0 : last_mem[rd_ptr_q];
    assign rd_empty   = empty;
    assign fifo_full  = full;
    assign fifo_count = count_q;
    assign byte_cnt   = byte_cnt_q;
    assign tag_out    = tag_q;
    assign busy       = (state_q == S_COLLECT);
    assign done       = (state_q == S_DONE);
    assign tag_match  = match_q;
    assign overflow   = ovf_q;
    assign seq_err    = seq_q;

endmodule

// File: tb/tb_gcm_out_collector.sv
// Randomized and directed bench for gcm_out_collector: a transaction-level model predicts
// status, and a scoreboard queue checks every word popped from the buffer.
module tb_gcm_out_collector;

    localparam int DEPTH = 4;
    localparam logic [127:0] NomTag = 128'h5bc94fbc3221a5db94fae95ae7121a47;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic [127:0] Out_data = '0;
    logic         Out_vld = 1'b0;
    logic         Tag_vld = 1'b0;
    logic [3:0]   Out_data_size = '0;
    logic         Out_last_word = 1'b0;
    logic         start = 1'b0;
    logic [127:0] exp_tag = '0;
    logic         rd_en = 1'b0;
    logic [127:0] rd_data;
    logic [3:0]   rd_size;
    logic         rd_last, rd_empty, fifo_full;
    logic [2:0]   fifo_count;
    logic [15:0]  byte_cnt;
    logic [127:0] tag_out;
    logic         busy, done, tag_match, overflow, seq_err;

    always #5 clk = ~clk;

    gcm_out_collector #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .clrn(clrn), .Out_data(Out_data), .Out_vld(Out_vld), .Tag_vld(Tag_vld),
        .Out_data_size(Out_data_size), .Out_last_word(Out_last_word), .start(start),
        .exp_tag(exp_tag), .rd_en(rd_en), .rd_data(rd_data), .rd_size(rd_size),
        .rd_last(rd_last), .rd_empty(rd_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .byte_cnt(byte_cnt), .tag_out(tag_out), .busy(busy),
        .done(done), .tag_match(tag_match), .overflow(overflow), .seq_err(seq_err)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   s;
        logic         l;
    } word_t;

    word_t        sb[$];
    int           total = 0;
    int           bad = 0;
    // Behavioural model: phase 0 idle, 1 collecting, 2 done.
    int           m_cnt, m_phase;
    int unsigned  m_bytes;
    logic [127:0] m_tag, m_exp;
    bit           m_match, m_ovf, m_seq, m_last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mask(input logic [127:0] d, input logic [3:0] s);
        logic [127:0] m = '1;
        if (s != 4'd15) m = (128'd1 << (8 * (int'(s) + 1))) - 128'd1;
        return d & m;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_bytes = 0; m_tag = '0; m_exp = '0;
        m_match = 0; m_ovf = 0; m_seq = 0; m_last = 0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, advance the model, and return 1ns after the committing edge.
    task automatic step(input bit st, input bit vld, input bit tg, input logic [127:0] d,
                        input logic [3:0] sz, input bit lw, input bit rd,
                        input logic [127:0] et);
        bit pop;
        start = st; Out_vld = vld; Tag_vld = tg; Out_data = d; Out_data_size = sz;
        Out_last_word = lw; rd_en = rd; exp_tag = et;
        if (st) begin
            model_reset();
            m_exp = et;
            m_phase = 1;
        end else begin
            pop = rd && (m_cnt > 0);
            if (m_phase == 1 && vld && !tg) begin
                if (m_last) m_seq = 1;
                if (m_cnt < DEPTH || pop) begin
                    sb.push_back(word_t'{mask(d, sz), sz, lw});
                    m_bytes = (m_bytes + sz + 1 > 65535) ? 65535 : m_bytes + sz + 1;
                    if (lw) m_last = 1;
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_phase == 1 && vld && tg) begin
                m_tag = d;
                m_match = (d == m_exp);
                if (!m_last) m_seq = 1;
                m_phase = 2;
            end else if (m_phase == 2 && vld) begin
                m_seq = 1;
            end
            if (pop) m_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rd);
        step(0, 0, 0, '0, 4'd0, 0, rd, '0);
    endtask

    task automatic data(input logic [3:0] sz, input bit lw, input bit rd);
        step(0, 1, 0, rnd128(), sz, lw, rd, '0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_empty"}, rd_empty, m_cnt == 0);
        chk({tag, "_full"}, fifo_full, m_cnt == DEPTH);
        chk({tag, "_count"}, fifo_count, m_cnt);
        chk({tag, "_bytes"}, byte_cnt, m_bytes);
        chk({tag, "_busy"}, busy, m_phase == 1);
        chk({tag, "_done"}, done, m_phase == 2);
        chk({tag, "_match"}, tag_match, m_match);
        chk({tag, "_tag"}, tag_out, m_tag);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_seq"}, seq_err, m_seq);
        if (m_cnt == 0) chk({tag, "_rdzero"}, {rd_data, rd_size, rd_last}, '0);
    endtask

    // Monitor: every real pop must match the oldest expected word.
    always @(negedge clk) begin
        word_t w;
        if (clrn && rd_en && !start && !rd_empty) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %h expected no word", rd_data);
            end else begin
                w = sb.pop_front();
                chk("pop_data", rd_data, w.d);
                chk("pop_size", rd_size, w.s);
                chk("pop_last", rd_last, w.l);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        clrn = 1'b1;

        // Nominal flow with matching tag
        step(1, 0, 0, '0, 4'd0, 0, 0, NomTag);
        data(4'd15, 0, 0); data(4'd15, 0, 0); data(4'd15, 0, 0); data(4'd11, 1, 0);
        step(0, 1, 1, NomTag, 4'd0, 0, 0, '0);
        idle(0);
        check_status("nom");
        chk("nom_bytes60", byte_cnt, 60);
        chk("nom_done", done, 1);
        chk("nom_tagmatch", tag_match, 1);
        idle(1); idle(1); idle(1);
        chk("nom_w4_last", rd_last, 1);
        chk("nom_w4_hi", rd_data[127:96], 0);
        idle(1);
        check_status("nom_drained");

        // Tag mismatch in bit 0
        step(1, 0, 0, '0, 4'd0, 0, 0, NomTag);
        data(4'd15, 0, 0); data(4'd15, 0, 0); data(4'd15, 0, 0); data(4'd11, 1, 0);
        step(0, 1, 1, NomTag ^ 128'd1, 4'd0, 0, 0, '0);
        check_status("mis");
        chk("mis_tagout", tag_out, NomTag ^ 128'd1);
        chk("mis_match", tag_match, 0);

        // Overflow without reads, then with a pop on the fifth word
        step(1, 0, 0, '0, 4'd0, 0, 0, rnd128());
        repeat (5) data(4'd15, 0, 0);
        check_status("ovf");
        chk("ovf_flag", overflow, 1);
        chk("ovf_bytes64", byte_cnt, 64);
        step(1, 0, 0, '0, 4'd0, 0, 0, rnd128());
        repeat (4) data(4'd15, 0, 0);
        data(4'd15, 0, 1);
        check_status("ovf_pop");
        chk("ovf_pop_flag", overflow, 0);
        chk("ovf_pop_count", fifo_count, 4);

        // Sequence errors, then pop on empty
        step(1, 0, 0, '0, 4'd0, 0, 0, NomTag);
        data(4'd7, 0, 0);
        step(0, 1, 1, rnd128(), 4'd0, 0, 0, '0);
        check_status("seq");
        chk("seq_err_tag", seq_err, 1);
        data(4'd3, 1, 0);
        check_status("seq_done");
        chk("seq_bytes", byte_cnt, 8);
        idle(1);
        idle(1);
        check_status("seq_rdempty");
        chk("seq_rdempty_cnt", fifo_count, 0);

        // Restart mid-collection
        step(1, 0, 0, '0, 4'd0, 0, 0, rnd128());
        data(4'd15, 1, 0); data(4'd2, 0, 0); data(4'd5, 0, 0);
        step(1, 1, 0, rnd128(), 4'd9, 0, 0, rnd128());
        check_status("restart");
        chk("restart_busy", busy, 1);
        chk("restart_count", fifo_count, 0);

        // Asynchronous reset mid-collection with two words buffered
        step(1, 0, 0, '0, 4'd0, 0, 0, rnd128());
        data(4'd4, 0, 0); data(4'd8, 0, 0);
        clrn = 1'b0;
        #2;
        model_reset();
        check_status("arst");
        chk("arst_empty", rd_empty, 1);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        idle(0);
        check_status("arst_after");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit st, vld, tg, lw, rd;
            logic [127:0] d;
            st  = ($urandom_range(0, 24) == 0);
            vld = ($urandom_range(0, 1) == 1);
            tg  = ($urandom_range(0, 9) == 0);
            lw  = ($urandom_range(0, 5) == 0);
            rd  = ($urandom_range(0, 2) == 0) && !st;
            d   = (tg && $urandom_range(0, 1) == 1) ? m_exp : rnd128();
            step(st, vld, tg, d, 4'($urandom_range(0, 15)), lw, rd, rnd128());
            check_status("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
